// File: rtl/ball_pkg.sv
// Shared types, constants and the step-period helper for the ball mover.
package ball_pkg;

  localparam int LEDS = 10;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    RUN   = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Faster speeds give shorter periods: speed 3 -> one tick unit, speed 0 -> four.
  function automatic logic [31:0] period(input logic [1:0] speed, input logic [31:0] tick_base);
    return tick_base * (32'd4 - {30'd0, speed});
  endfunction

endpackage

// File: rtl/ball_mover_step_timer.sv
// Loadable down-counter that flags the cycle on which the current step period ends.
module step_timer #(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          enable,
  output logic          expire
);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (enable && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // The owner reloads on expiry, so the count never sits at 1 for more than one enabled cycle.
  assign expire = enable && (count_reg == TW'(1));

endmodule

// File: rtl/ball_mover.sv
// Ball position FSM: serve parking, timed stepping, edge-of-court miss reporting.
// Optional rally counter output is built when BALL_MOVER_RALLY_EN is defined.
module ball_mover #(
  parameter int LEDS      = ball_pkg::LEDS,
  parameter int TICK_BASE = 12500000,
  parameter int TW        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      speed,
  input  logic            direction,
  input  logic            halt,
  input  logic            rstball,
  input  logic            ball,
  output logic [LEDS-1:0] position,
  output logic            outside,
  output logic            winner
`ifdef BALL_MOVER_RALLY_EN
  ,
  output logic [7:0]      rally_cnt
`endif
);

  import ball_pkg::*;

  state_t          state_reg, state_next;
  logic [LEDS-1:0] pos_reg, pos_next, park;
  logic            winner_reg, winner_next;
  logic            dir_reg;
  logic [1:0]      speed_reg;
  logic            changed, run_go, expire, do_step, at_edge;
  logic            t_load, t_enable;
  logic [TW-1:0]   t_val, period_now;

  assign park       = ball ? LEDS'(1) : (LEDS'(1) << (LEDS - 1));
  assign changed    = (direction != dir_reg) || (speed != speed_reg);
  assign run_go     = (state_reg == RUN) && !halt && !rstball;
  // A hit (direction or speed change) restarts the period instead of stepping.
  assign do_step    = run_go && !changed && expire;
  assign at_edge    = (direction == DIR_UP) ? pos_reg[LEDS-1] : pos_reg[0];
  assign period_now = TW'(period(speed, 32'(TICK_BASE)));

  step_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .enable   (t_enable),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= SERVE;
      pos_reg    <= LEDS'(1);
      winner_reg <= 1'b0;
      dir_reg    <= 1'b0;
      speed_reg  <= 2'd0;
    end else begin
      state_reg  <= state_next;
      pos_reg    <= pos_next;
      winner_reg <= winner_next;
      dir_reg    <= direction;
      speed_reg  <= speed;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (rstball) begin
      state_next = SERVE;
    end else begin
      case (state_reg)
        SERVE:   if (!halt) state_next = RUN;
        RUN:     if (do_step && at_edge) state_next = OUT;
        OUT:     state_next = SERVE;
        default: state_next = SERVE;
      endcase
    end
  end

  always_comb begin
    pos_next    = pos_reg;
    winner_next = winner_reg;
    t_enable    = (state_reg == RUN) && !halt;
    t_load      = (state_reg != RUN) || rstball || (!halt && (changed || expire));
    t_val       = (state_next == RUN) ? period_now : '0;
    if (state_next == SERVE) begin
      pos_next = park;
    end else if (state_next == OUT) begin
      pos_next    = '0;
      winner_next = (direction == DIR_UP);
    end else if (do_step) begin
      pos_next = (direction == DIR_UP) ? (pos_reg << 1) : (pos_reg >> 1);
    end
  end

  always_comb begin
    position = pos_reg;
    outside  = (state_reg == OUT);
    winner   = winner_reg;
  end

`ifdef BALL_MOVER_RALLY_EN
  logic [7:0] rally_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rally_reg <= 8'd0;
    end else if (state_next == SERVE) begin
      rally_reg <= 8'd0;
    end else if (state_reg == RUN && direction != dir_reg && rally_reg != 8'hFF) begin
      rally_reg <= rally_reg + 8'd1;
    end
  end

  assign rally_cnt = rally_reg;
`endif

endmodule

// File: doc/ball_mover.md
Name: ball_mover

Overview:
- Downstream stage of the game controller: consumes speed, direction, halt, rstball and ball (server select).
- Drives the 10-LED one-hot ball position plus the outside/winner pair that the controller scores on.
- Owns the step timer, serve parking, edge-of-court detection and miss reporting.
- Index 0 is player-1's end; index 9 is player-2's end.

Parameters:
- LEDS, 10, court length in LEDs; one-hot position width.
- TICK_BASE, 12500000, clock cycles per step unit; step period = TICK_BASE*(4-speed).
- TW, 32, step-timer counter width; must hold 4*TICK_BASE.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- speed, input, 2, ball speed 0..3 (3 fastest).
- direction, input, 1, 0 = toward index 9 (away from p1), 1 = toward index 0.
- halt, input, 1, freeze ball, level.
- rstball, input, 1, force re-serve, level, sampled each clk.
- ball, input, 1, server: 1 = p1 (park at index 0), 0 = p2 (park at index 9).
- position, output, LEDS, one-hot ball LED; all-zero only in OUT.
- outside, output, 1, one-cycle pulse when ball leaves court.
- winner, output, 1, 1 = p1 won point, 0 = p2; valid with outside, held until next pulse.

Behaviour:
- Reset (rst_n low, async): state = SERVE, position = 10'b0000000001, outside = 0, winner = 0, timer = 0.
- SERVE state:
  - position tracks ball each cycle (1 -> bit0, 0 -> bit9), registered, 1-cycle latency.
  - Timer held at 0.
  - halt = 0 -> RUN; timer loads period(speed).
- RUN state:
  - halt = 1: position and timer frozen; no outside pulses.
  - halt = 0: timer decrements once per cycle.
  - At timer == 1, step: direction 0 shifts position left (index+1), direction 1 shifts right (index-1). Timer reloads period(speed) in the same cycle.
  - Step out of court: step from bit9 with direction 0, or from bit0 with direction 1 -> OUT instead of shifting.
  - Direction or speed change (vs. value registered last cycle) reloads timer with the new period. Position does not move that cycle, so a hit always gets a full period before the next step.
- OUT state (exactly one cycle):
  - position = 0, outside = 1.
  - winner = 1 if exit past bit9 (p2 missed), 0 if exit past bit0.
  - Next cycle -> SERVE; outside returns to 0.
- rstball = 1 in any state: next state SERVE, position parked per ball, outside forced 0. rstball has priority over a pending step or OUT entry in the same cycle.
- Simultaneous halt = 1 and timer expiry: halt wins; no step.
- period(speed) = TICK_BASE*(4-speed), computed in TW bits; speed 0 gives 4*TICK_BASE, speed 3 gives TICK_BASE.
- position is always one-hot except during the OUT cycle; the bench asserts this.
- Reset asserted mid-RUN: immediate return to reset values, no outside pulse.

Optional Feature:
- Macro: BALL_MOVER_RALLY_EN.
- Defined:
  - Adds output rally_cnt[7:0]: count of direction changes while in RUN.
  - Saturates at 255; cleared on entry to SERVE and on reset.
- Undefined: no rally_cnt port; no counter logic.

Decomposition:
- Package ball_pkg:
  - LEDS constant.
  - State enum {SERVE, RUN, OUT}.
  - Direction constants DIR_UP = 0, DIR_DOWN = 1.
  - Function period(speed, TICK_BASE).
- Sub-module step_timer:
  - Inputs: load, load_val, enable.
  - Output: expire pulse.
  - Behaviour: loadable down-counter.
- ball_mover holds the FSM and shift register.

Test Plan (TICK_BASE = 4):
- Reset, ball = 1, halt = 1 -> position = 0x001, outside = 0. Flip ball = 0 -> position = 0x200 one cycle later.
- ball = 1, speed = 3, direction = 0, halt = 0 -> position advances one bit every 4 cycles to 0x200. Next step gives position = 0, outside = 1 for exactly 1 cycle, winner = 1. Then position = 0x001 (serve parked).
- speed = 0 -> step spacing 16 cycles. Change speed to 2 mid-period -> next step exactly 8 cycles after the change.
- Ball at 0x080 moving up; flip direction = 1 -> no step that cycle, then 0x040 4 cycles later (speed 3). Run down past bit0 -> outside pulse with winner = 0.
- halt = 1 for 20 cycles mid-run -> position constant, no outside. Release -> remaining timer count resumes.
- rstball = 1 on the same cycle a step off bit9 is due -> no outside pulse, position parked per ball. With BALL_MOVER_RALLY_EN: 3 direction flips -> rally_cnt = 3, then 0 after rstball.
